// File: rtl/avalon_bus_read_verify.sv
`default_nettype none
// ============================================================================
// Module   : avalon_bus_read_verify
// Purpose  : Avalon-MM read master that reads back the frame buffer once the
//            pattern writer has filled it. It issues pipelined single-word
//            reads, keeps up to MAX_OUTSTANDING reads in flight, and compares
//            every returned word against the expected pattern:
//              PATTERN_LO for word index <  SPLIT
//              PATTERN_HI for word index >= SPLIT (up to NUM_WORDS-1)
//            It reports busy/done/pass and a saturating mismatch count.
//
// Ports    : iCLK, iRST_n (async, active low)  clock / reset
//            iSTART             sync start pulse (needs local_init_done)
//            local_init_done    memory controller calibrated
//            avl_waitrequest_n  slave accepts the request when high
//            avl_address        read word address
//            avl_read           read request
//            avl_burstbegin     same as avl_read (burst length 1)
//            avl_readdata       returned data
//            avl_readdatavalid  avl_readdata valid this cycle
//            oBUSY              state is READ or DRAIN
//            oDONE              state is DONE
//            oPASS              DONE with zero mismatches
//            oERR_COUNT         mismatch count, saturates at all-ones
//            c_state            state code (debug)
//
// Options  : FIRST_ERR_CAPTURE_EN - adds oFIRST_ERR_ADDR / oFIRST_ERR_DATA,
//            holding the word index and data of the first mismatch of a run.
//
// Revision : 1.0 - initial release
// ============================================================================
module avalon_bus_read_verify #(
  parameter int                ADDR_W          = 27,
  parameter int                DATA_W          = 32,
  parameter int                NUM_WORDS       = 2073600,
  parameter int                SPLIT           = 1036800,
  parameter logic [DATA_W-1:0] PATTERN_LO      = 32'h0055AA55,
  parameter logic [DATA_W-1:0] PATTERN_HI      = 32'h00BB6666,
  parameter int                MAX_OUTSTANDING = 8,
  parameter int                ERR_W           = 16
) (
  input  logic              iCLK,
  input  logic              iRST_n,
  input  logic              iSTART,
  input  logic              local_init_done,
  input  logic              avl_waitrequest_n,
  output logic [ADDR_W-1:0] avl_address,
  output logic              avl_read,
  output logic              avl_burstbegin,
  input  logic [DATA_W-1:0] avl_readdata,
  input  logic              avl_readdatavalid,
  output logic              oBUSY,
  output logic              oDONE,
  output logic              oPASS,
  output logic [ERR_W-1:0]  oERR_COUNT,
  output logic [3:0]        c_state
`ifdef FIRST_ERR_CAPTURE_EN
  ,
  output logic [ADDR_W-1:0] oFIRST_ERR_ADDR,
  output logic [DATA_W-1:0] oFIRST_ERR_DATA
`endif
);

  localparam int OUT_W = $clog2(MAX_OUTSTANDING) + 1;

  localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(NUM_WORDS - 1);
  localparam logic [ADDR_W-1:0] c_NUM_IDX   = ADDR_W'(NUM_WORDS);
  localparam logic [ADDR_W-1:0] c_SPLIT_IDX = ADDR_W'(SPLIT);
  localparam logic [ADDR_W-1:0] c_ONE_ADDR  = ADDR_W'(1);
  localparam logic [OUT_W-1:0]  c_MAX_OUT   = OUT_W'(MAX_OUTSTANDING);
  localparam logic [OUT_W-1:0]  c_ONE_OUT   = OUT_W'(1);
  localparam logic [ERR_W-1:0]  c_ONE_ERR   = ERR_W'(1);

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_READ  = 4'd1,
    ST_DRAIN = 4'd2,
    ST_DONE  = 4'd9
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_rd_idx;
  logic [OUT_W-1:0]  r_outstanding;
  logic [ERR_W-1:0]  r_err;

  logic              w_read;
  logic              w_clear;
  logic              w_start_ok;
  logic              w_accept;
  logic              w_ret;
  logic              w_last_ret;
  logic              w_mismatch;
  logic [DATA_W-1:0] w_expected;

  assign w_start_ok = iSTART && local_init_done;
  assign w_accept   = w_read && avl_waitrequest_n;
  // A return with nothing in flight is stray (e.g. from before a reset).
  assign w_ret      = avl_readdatavalid && (r_outstanding != '0);
  // Final return is taking place now; lets DONE follow it by one cycle.
  assign w_last_ret = w_ret && (r_rd_idx == c_LAST_ADDR) && (r_outstanding == c_ONE_OUT);
  assign w_expected = (r_rd_idx < c_SPLIT_IDX) ? PATTERN_LO : PATTERN_HI;
  assign w_mismatch = w_ret && (avl_readdata != w_expected);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and request generation
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    w_read       = 1'b0;
    w_clear      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_clear = 1'b1;
        if (w_start_ok) begin
          w_next_state = ST_READ;
        end
      end
      ST_READ: begin
        // Outstanding only grows on accept, so once raised the request
        // stays up with a stable address until the slave takes it.
        w_read = (r_outstanding < c_MAX_OUT);
        if (w_read && avl_waitrequest_n && (r_addr == c_LAST_ADDR)) begin
          w_next_state = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_last_ret || ((r_rd_idx == c_NUM_IDX) && (r_outstanding == '0))) begin
          w_next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        // Restart clears the counters on this edge and goes straight to READ.
        if (w_start_ok) begin
          w_clear      = 1'b1;
          w_next_state = ST_READ;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Address, outstanding, return index and error counters
  // --------------------------------------------------------------------------
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_addr        <= '0;
      r_rd_idx      <= '0;
      r_outstanding <= '0;
      r_err         <= '0;
    end else if (w_clear) begin
      r_addr        <= '0;
      r_rd_idx      <= '0;
      r_outstanding <= '0;
      r_err         <= '0;
    end else begin
      if (w_accept) begin
        r_addr <= r_addr + c_ONE_ADDR;
      end
      case ({w_accept, w_ret})
        2'b10:   r_outstanding <= r_outstanding + c_ONE_OUT;
        2'b01:   r_outstanding <= r_outstanding - c_ONE_OUT;
        default: r_outstanding <= r_outstanding;
      endcase
      if (w_ret) begin
        r_rd_idx <= r_rd_idx + c_ONE_ADDR;
      end
      if (w_mismatch && (r_err != '1)) begin
        r_err <= r_err + c_ONE_ERR;
      end
    end
  end

`ifdef FIRST_ERR_CAPTURE_EN
  // --------------------------------------------------------------------------
  // First-mismatch capture
  // --------------------------------------------------------------------------
  logic r_first_seen;
  logic [ADDR_W-1:0] r_first_addr;
  logic [DATA_W-1:0] r_first_data;

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_first_seen <= 1'b0;
      r_first_addr <= '0;
      r_first_data <= '0;
    end else if (w_clear) begin
      r_first_seen <= 1'b0;
      r_first_addr <= '0;
      r_first_data <= '0;
    end else if (w_mismatch && !r_first_seen) begin
      r_first_seen <= 1'b1;
      r_first_addr <= r_rd_idx;
      r_first_data <= avl_readdata;
    end
  end

  assign oFIRST_ERR_ADDR = r_first_addr;
  assign oFIRST_ERR_DATA = r_first_data;
`endif

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign avl_address    = r_addr;
  assign avl_read       = w_read;
  assign avl_burstbegin = w_read;
  assign oBUSY          = (r_state == ST_READ) || (r_state == ST_DRAIN);
  assign oDONE          = (r_state == ST_DONE);
  assign oPASS          = (r_state == ST_DONE) && (r_err == '0);
  assign oERR_COUNT     = r_err;
  assign c_state        = r_state;

endmodule
`default_nettype wire

// File: tb/tb_avalon_bus_read_verify.sv
`default_nettype none
// ============================================================================
// Module   : tb_avalon_bus_read_verify
// Purpose  : Directed testbench for avalon_bus_read_verify with a small
//            in-order Avalon memory model (configurable latency and
//            waitrequest). 64 words, split at 32, 4 reads in flight,
//            4-bit error counter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_avalon_bus_read_verify;

  localparam int ADDR_W    = 27;
  localparam int DATA_W    = 32;
  localparam int NUM_WORDS = 64;
  localparam int SPLIT     = 32;
  localparam int MAXO      = 4;
  localparam int ERR_W     = 4;
  localparam logic [31:0] LO = 32'h0055AA55;
  localparam logic [31:0] HI = 32'h00BB6666;

  logic              iCLK = 1'b0;
  logic              iRST_n = 1'b0;
  logic              iSTART = 1'b0;
  logic              local_init_done = 1'b0;
  logic              avl_waitrequest_n = 1'b1;
  logic              avl_readdatavalid = 1'b0;
  logic [DATA_W-1:0] avl_readdata = '0;
  logic [ADDR_W-1:0] avl_address;
  logic              avl_read;
  logic              avl_burstbegin;
  logic              oBUSY;
  logic              oDONE;
  logic              oPASS;
  logic [ERR_W-1:0]  oERR_COUNT;
  logic [3:0]        c_state;
`ifdef FIRST_ERR_CAPTURE_EN
  logic [ADDR_W-1:0] oFIRST_ERR_ADDR;
  logic [DATA_W-1:0] oFIRST_ERR_DATA;
`endif

  always #5 iCLK = ~iCLK;

  avalon_bus_read_verify #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_WORDS(NUM_WORDS), .SPLIT(SPLIT),
    .PATTERN_LO(LO), .PATTERN_HI(HI), .MAX_OUTSTANDING(MAXO), .ERR_W(ERR_W)
  ) dut (
    .iCLK(iCLK), .iRST_n(iRST_n), .iSTART(iSTART), .local_init_done(local_init_done),
    .avl_waitrequest_n(avl_waitrequest_n), .avl_address(avl_address),
    .avl_read(avl_read), .avl_burstbegin(avl_burstbegin),
    .avl_readdata(avl_readdata), .avl_readdatavalid(avl_readdatavalid),
    .oBUSY(oBUSY), .oDONE(oDONE), .oPASS(oPASS), .oERR_COUNT(oERR_COUNT),
    .c_state(c_state)
`ifdef FIRST_ERR_CAPTURE_EN
    , .oFIRST_ERR_ADDR(oFIRST_ERR_ADDR), .oFIRST_ERR_DATA(oFIRST_ERR_DATA)
`endif
  );

  // Memory model state
  logic [31:0]       mem [NUM_WORDS];
  int                due_q[$];
  logic [31:0]       data_q[$];
  int                cyc = 0;
  int                last_due = 0;
  int                last_ret_cyc = 0;
  int                model_out = 0;
  int                accept_cnt = 0;
  int                seq_err = 0;
  int                out_viol = 0;
  int                stall_viol = 0;
  logic [ADDR_W-1:0] exp_addr = '0;
  logic [ADDR_W-1:0] prev_addr = '0;
  bit                rand_mode = 1'b0;
  bit                stray_en = 1'b0;
  bit                start_req = 1'b0;
  bit                prev_stall = 1'b0;
  bit                last_read = 1'b0;
  bit                to;

  int n_checks = 0;
  int n_pass   = 0;

  // One bus cycle: inputs change on the falling edge, DUT samples on rising.
  task automatic bus_cycle();
    int lat;
    bit acc;
    @(negedge iCLK);
    cyc++;
    iSTART = start_req;
    start_req = 1'b0;
    last_read = avl_read;
    if (prev_stall && (!avl_read || (avl_address != prev_addr))) stall_viol++;
    avl_waitrequest_n = rand_mode ? ($urandom_range(0, 99) < 60) : 1'b1;
    acc = avl_read && avl_waitrequest_n && iRST_n;
    prev_stall = avl_read && !avl_waitrequest_n;
    prev_addr = avl_address;
    if (acc) begin
      if (avl_address != exp_addr) seq_err++;
      lat = rand_mode ? int'($urandom_range(1, 12)) : 3;
      if (cyc + lat <= last_due) last_due = last_due + 1;
      else last_due = cyc + lat;
      due_q.push_back(last_due);
      data_q.push_back((avl_address < NUM_WORDS) ? mem[avl_address[5:0]] : 32'hxxxxxxxx);
      exp_addr = exp_addr + 1'b1;
      accept_cnt++;
      model_out++;
    end
    if (due_q.size() > 0 && due_q[0] <= cyc) begin
      avl_readdatavalid = 1'b1;
      avl_readdata = data_q.pop_front();
      void'(due_q.pop_front());
      last_ret_cyc = cyc;
      if (model_out > 0) model_out--;
    end else if (stray_en) begin
      avl_readdatavalid = 1'b1;
      avl_readdata = 32'hDEADBEEF;
    end else begin
      avl_readdatavalid = 1'b0;
      avl_readdata = '0;
    end
    if (model_out > MAXO) out_viol++;
  endtask

  task automatic fill_clean();
    for (int i = 0; i < NUM_WORDS; i++) mem[i] = (i < SPLIT) ? LO : HI;
  endtask

  // Start pulse, then one more cycle so the first request is visible.
  task automatic start_run();
    exp_addr = '0;
    accept_cnt = 0;
    seq_err = 0;
    out_viol = 0;
    stall_viol = 0;
    local_init_done = 1'b1;
    start_req = 1'b1;
    bus_cycle();
    bus_cycle();
  endtask

  task automatic run_to_done(input int budget, output bit timed_out);
    int n = 0;
    while (!oDONE && n < budget) begin
      bus_cycle();
      n++;
    end
    timed_out = !oDONE;
  endtask

  task automatic test_reset();
    iRST_n = 1'b0;
    bus_cycle();
    bus_cycle();
    n_checks++; if ({avl_read, avl_burstbegin, oBUSY, oDONE, oPASS} !== 5'b0) $display("FAIL reset_flags: got %b want 00000", {avl_read, avl_burstbegin, oBUSY, oDONE, oPASS}); else n_pass++;
    n_checks++; if (avl_address !== '0) $display("FAIL reset_addr: got %0d want 0", avl_address); else n_pass++;
    n_checks++; if (c_state !== 4'd0) $display("FAIL reset_state: got %0d want 0", c_state); else n_pass++;
    n_checks++; if (oERR_COUNT !== '0) $display("FAIL reset_err: got %0d want 0", oERR_COUNT); else n_pass++;
    iRST_n = 1'b1;
    bus_cycle();
  endtask

  task automatic test_no_init();
    local_init_done = 1'b0;
    start_req = 1'b1;
    bus_cycle();
    stray_en = 1'b1;
    for (int i = 0; i < 4; i++) bus_cycle();
    stray_en = 1'b0;
    bus_cycle();
    n_checks++; if (c_state !== 4'd0) $display("FAIL noinit_state: got %0d want 0", c_state); else n_pass++;
    n_checks++; if (avl_read !== 1'b0) $display("FAIL noinit_read: got %b want 0", avl_read); else n_pass++;
    n_checks++; if (oERR_COUNT !== '0) $display("FAIL stray_err: got %0d want 0", oERR_COUNT); else n_pass++;
    n_checks++; if (oBUSY !== 1'b0) $display("FAIL noinit_busy: got %b want 0", oBUSY); else n_pass++;
  endtask

  task automatic test_clean();
    fill_clean();
    rand_mode = 1'b0;
    start_run();
    n_checks++; if (last_read !== 1'b1) $display("FAIL clean_read_rise: got %b want 1", last_read); else n_pass++;
    n_checks++; if (c_state !== 4'd1) $display("FAIL clean_state_read: got %0d want 1", c_state); else n_pass++;
    n_checks++; if (oBUSY !== 1'b1) $display("FAIL clean_busy: got %b want 1", oBUSY); else n_pass++;
    run_to_done(2000, to);
    n_checks++; if (to !== 1'b0) $display("FAIL clean_timeout: got %b want 0", to); else n_pass++;
    n_checks++; if (accept_cnt !== 64) $display("FAIL clean_accepts: got %0d want 64", accept_cnt); else n_pass++;
    n_checks++; if (seq_err !== 0) $display("FAIL clean_addr_seq: got %0d want 0", seq_err); else n_pass++;
    n_checks++; if (oPASS !== 1'b1) $display("FAIL clean_pass: got %b want 1", oPASS); else n_pass++;
    n_checks++; if (oERR_COUNT !== '0) $display("FAIL clean_err: got %0d want 0", oERR_COUNT); else n_pass++;
    n_checks++; if (avl_address !== 27'd64) $display("FAIL clean_addr_end: got %0d want 64", avl_address); else n_pass++;
    n_checks++; if (c_state !== 4'd9) $display("FAIL clean_state_done: got %0d want 9", c_state); else n_pass++;
    n_checks++; if (oBUSY !== 1'b0) $display("FAIL clean_busy_done: got %b want 0", oBUSY); else n_pass++;
    n_checks++; if (cyc !== last_ret_cyc + 1) $display("FAIL clean_done_timing: got cycle %0d want %0d", cyc, last_ret_cyc + 1); else n_pass++;
  endtask

  task automatic test_corrupt();
    fill_clean();
    mem[5]  = 32'h0055AA54;
    mem[32] = 32'h00BB6667;
    start_run();
    run_to_done(2000, to);
    n_checks++; if (to !== 1'b0) $display("FAIL corrupt_timeout: got %b want 0", to); else n_pass++;
    n_checks++; if (oERR_COUNT !== 4'd2) $display("FAIL corrupt_err: got %0d want 2", oERR_COUNT); else n_pass++;
    n_checks++; if (oPASS !== 1'b0) $display("FAIL corrupt_pass: got %b want 0", oPASS); else n_pass++;
    n_checks++; if (oDONE !== 1'b1) $display("FAIL corrupt_done: got %b want 1", oDONE); else n_pass++;
`ifdef FIRST_ERR_CAPTURE_EN
    n_checks++; if (oFIRST_ERR_ADDR !== 27'd5) $display("FAIL corrupt_first_addr: got %0d want 5", oFIRST_ERR_ADDR); else n_pass++;
    n_checks++; if (oFIRST_ERR_DATA !== 32'h0055AA54) $display("FAIL corrupt_first_data: got %h want 0055aa54", oFIRST_ERR_DATA); else n_pass++;
`endif
  endtask

  task automatic test_restart_from_done();
    fill_clean();
    start_run();
    n_checks++; if (oERR_COUNT !== '0) $display("FAIL restart_err_clear: got %0d want 0", oERR_COUNT); else n_pass++;
    n_checks++; if (oDONE !== 1'b0) $display("FAIL restart_done_clear: got %b want 0", oDONE); else n_pass++;
    n_checks++; if (last_read !== 1'b1) $display("FAIL restart_read_rise: got %b want 1", last_read); else n_pass++;
    run_to_done(2000, to);
    n_checks++; if (to !== 1'b0) $display("FAIL restart_timeout: got %b want 0", to); else n_pass++;
    n_checks++; if (accept_cnt !== 64) $display("FAIL restart_accepts: got %0d want 64", accept_cnt); else n_pass++;
    n_checks++; if (oPASS !== 1'b1) $display("FAIL restart_pass: got %b want 1", oPASS); else n_pass++;
  endtask

  task automatic test_random();
    fill_clean();
    rand_mode = 1'b1;
    start_run();
    local_init_done = 1'b0;
    run_to_done(4000, to);
    rand_mode = 1'b0;
    n_checks++; if (to !== 1'b0) $display("FAIL random_timeout: got %b want 0", to); else n_pass++;
    n_checks++; if (out_viol !== 0) $display("FAIL random_outstanding: got %0d violations want 0", out_viol); else n_pass++;
    n_checks++; if (stall_viol !== 0) $display("FAIL random_stall_stable: got %0d violations want 0", stall_viol); else n_pass++;
    n_checks++; if (seq_err !== 0) $display("FAIL random_addr_seq: got %0d want 0", seq_err); else n_pass++;
    n_checks++; if (accept_cnt !== 64) $display("FAIL random_accepts: got %0d want 64", accept_cnt); else n_pass++;
    n_checks++; if (oPASS !== 1'b1) $display("FAIL random_pass: got %b want 1", oPASS); else n_pass++;
  endtask

  task automatic test_saturate();
    for (int i = 0; i < NUM_WORDS; i++) mem[i] = 32'hFFFFFFFF;
    start_run();
    run_to_done(2000, to);
    n_checks++; if (to !== 1'b0) $display("FAIL sat_timeout: got %b want 0", to); else n_pass++;
    n_checks++; if (oERR_COUNT !== 4'hF) $display("FAIL sat_err: got %0d want 15", oERR_COUNT); else n_pass++;
    n_checks++; if (oPASS !== 1'b0) $display("FAIL sat_pass: got %b want 0", oPASS); else n_pass++;
`ifdef FIRST_ERR_CAPTURE_EN
    n_checks++; if (oFIRST_ERR_ADDR !== '0) $display("FAIL sat_first_addr: got %0d want 0", oFIRST_ERR_ADDR); else n_pass++;
    n_checks++; if (oFIRST_ERR_DATA !== 32'hFFFFFFFF) $display("FAIL sat_first_data: got %h want ffffffff", oFIRST_ERR_DATA); else n_pass++;
`endif
  endtask

  task automatic test_reset_mid();
    int n = 0;
    fill_clean();
    start_run();
    while (accept_cnt < 20 && n < 200) begin
      bus_cycle();
      n++;
    end
    n_checks++; if (accept_cnt !== 20) $display("FAIL midrst_reach20: got %0d want 20", accept_cnt); else n_pass++;
    iRST_n = 1'b0;
    model_out = 0;
    #1;
    n_checks++; if ({avl_read, oBUSY, oDONE, oPASS} !== 4'b0) $display("FAIL midrst_flags: got %b want 0000", {avl_read, oBUSY, oDONE, oPASS}); else n_pass++;
    n_checks++; if (avl_address !== '0) $display("FAIL midrst_addr: got %0d want 0", avl_address); else n_pass++;
    n_checks++; if (c_state !== 4'd0) $display("FAIL midrst_state: got %0d want 0", c_state); else n_pass++;
    bus_cycle();
    iRST_n = 1'b1;
    // Remaining in-flight returns arrive after release and must be ignored.
    for (int i = 0; i < 8; i++) bus_cycle();
    n_checks++; if (oERR_COUNT !== '0) $display("FAIL midrst_stale_err: got %0d want 0", oERR_COUNT); else n_pass++;
    n_checks++; if (c_state !== 4'd0) $display("FAIL midrst_idle: got %0d want 0", c_state); else n_pass++;
    start_run();
    run_to_done(2000, to);
    n_checks++; if (to !== 1'b0) $display("FAIL midrst_timeout: got %b want 0", to); else n_pass++;
    n_checks++; if (accept_cnt !== 64) $display("FAIL midrst_accepts: got %0d want 64", accept_cnt); else n_pass++;
    n_checks++; if (oPASS !== 1'b1) $display("FAIL midrst_pass: got %b want 1", oPASS); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_no_init();
    test_clean();
    test_corrupt();
    test_restart_from_done();
    test_random();
    test_saturate();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
